core_seq: RTL and testbench

- Instruction sequencer directly upstream of the core block; generates the 36-bit inst word every cycle for one convolution tile.
- Tile sequence: for each of ksize kernel positions, load weights from xmem through L0 into the MAC array, stream activations, and drain the OFIFO into psum memory.
- Then replays psum memory with inst[33] set so the SFP accumulates ksize partial sums per output and applies ReLU.
- Pure control. No data path; D_xmem is driven by the testbench or DMA.

---
 rtl/core_seq_if.sv | 26 ++
 rtl/core_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_core_seq.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_if.sv
// Instruction-bus bundle between the tile sequencer and the core block.
// The sequencer side (master) takes start/ofifo_valid and drives the
// 36-bit instruction word together with its busy/done status.
interface core_seq_if;
    logic        start;
    logic        ofifo_valid;
    logic [35:0] inst;
    logic        busy;
    logic        done;

    modport master (
        input  start,
        input  ofifo_valid,
        output inst,
        output busy,
        output done
    );

    modport slave (
        output start,
        output ofifo_valid,
        input  inst,
        input  busy,
        input  done
    );
endinterface

// File: rtl/core_seq.sv
// core_seq: instruction sequencer for one convolution tile.
// For each kernel position it loads weights into L0 and the MAC array,
// streams activations, then drains the OFIFO into psum memory.  After
// the last kernel position it replays psum memory with the accumulate
// bit set so the SFP sums ksize partials per output.
// Optional build macro CORE_SEQ_PERF_EN adds saturating stall_cnt and
// cycle_cnt output ports.
//
// inst field map:
//   [35] mode (0)   [34] reserved (0)   [33] acc
//   [32] pmem CEN_n [31] pmem WEN_n     [30:20] pmem address
//   [19] xmem CEN_n [18] xmem WEN_n     [17:7]  xmem address
//   [6] ofifo_rd    [5:4] unused (0)    [3] l0_rd  [2] l0_wr
//   [1] execute     [0] kernel load
module core_seq #(
    parameter int          row       = 8,
    parameter int          col       = 8,
    parameter int          ksize     = 9,
    parameter int          n_act     = 36,
    parameter logic [10:0] kern_base = 11'd0,
    parameter logic [10:0] act_base  = 11'd1024,
    parameter logic [10:0] psum_base = 11'd0
) (
    input  logic        clk,
    input  logic        reset,
`ifdef CORE_SEQ_PERF_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] cycle_cnt,
`endif
    core_seq_if.master  bus
);

    // Both SRAMs deselected (CEN_n/WEN_n high), every other bit low.
    localparam logic [35:0] INST_IDLE = 36'h1_8_0_0_C_0_0_0_0;

    localparam logic [15:0] C_COL   = 16'(col);
    localparam logic [15:0] C_NACT  = 16'(n_act);
    localparam logic [15:0] C_KSZ   = 16'(ksize);
    localparam logic [15:0] C_FLUSH = 16'(row + col);
    localparam logic [10:0] A_COL   = 11'(col);
    localparam logic [10:0] A_NACT  = 11'(n_act);

    typedef enum logic [2:0] {
        IDLE,
        KLD_L0,
        KLD_ARR,
        KFLUSH,
        ALD_EXEC,
        DRAIN,
        ACC,
        FIN
    } state_t;

    state_t      state;
    logic [15:0] cnt;      // cycle index in phase; OFIFO reads in DRAIN; output j in ACC
    logic [15:0] sub;      // psum writes in DRAIN; partial index k in ACC
    logic [15:0] k;        // current kernel position
    logic [10:0] addr;     // running SRAM address of the active phase
    logic [10:0] xbase;    // kern_base + k*col
    logic [10:0] abase;    // act_base  + k*n_act
    logic [10:0] pbase;    // psum_base + k*n_act
    logic [10:0] jbase;    // psum_base + j during ACC
    logic [35:0] inst_q;
    logic        done_q;

    assign bus.inst = inst_q;
    assign bus.done = done_q;
    assign bus.busy = (state != IDLE);

    // Tile FSM: decides the next instruction word and phase every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 16'd0;
            sub    <= 16'd0;
            k      <= 16'd0;
            addr   <= 11'd0;
            xbase  <= 11'd0;
            abase  <= 11'd0;
            pbase  <= 11'd0;
            jbase  <= 11'd0;
            inst_q <= INST_IDLE;
            done_q <= 1'b0;
        end else begin
            inst_q <= INST_IDLE;
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= KLD_L0;
                        cnt   <= 16'd0;
                        sub   <= 16'd0;
                        k     <= 16'd0;
                        xbase <= kern_base;
                        abase <= act_base;
                        pbase <= psum_base;
                        addr  <= kern_base;
                    end
                end

                KLD_L0: begin
                    // col weight reads; L0 write trails each read by one cycle
                    if (cnt < C_COL) begin
                        inst_q[19]   <= 1'b0;
                        inst_q[18]   <= 1'b1;
                        inst_q[17:7] <= addr;
                        addr         <= addr + 11'd1;
                    end
                    if (cnt != 16'd0) begin
                        inst_q[2] <= 1'b1;
                    end
                    if (cnt == C_COL) begin
                        state <= KLD_ARR;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                KLD_ARR: begin
                    inst_q[3] <= 1'b1;
                    inst_q[0] <= 1'b1;
                    if (cnt == C_COL - 16'd1) begin
                        state <= KFLUSH;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                KFLUSH: begin
                    // weights ripple through row+col array stages
                    if (cnt == C_FLUSH - 16'd1) begin
                        state <= ALD_EXEC;
                        cnt   <= 16'd0;
                        addr  <= abase;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                ALD_EXEC: begin
                    // read at t, L0 write at t+1, L0 read + execute at t+2
                    if (cnt < C_NACT) begin
                        inst_q[19]   <= 1'b0;
                        inst_q[18]   <= 1'b1;
                        inst_q[17:7] <= addr;
                        addr         <= addr + 11'd1;
                    end
                    if ((cnt != 16'd0) && (cnt <= C_NACT)) begin
                        inst_q[2] <= 1'b1;
                    end
                    if (cnt >= 16'd2) begin
                        inst_q[3] <= 1'b1;
                        inst_q[1] <= 1'b1;
                    end
                    if (cnt == C_NACT + 16'd1) begin
                        state <= DRAIN;
                        cnt   <= 16'd0;
                        sub   <= 16'd0;
                        addr  <= pbase;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                DRAIN: begin
                    // OFIFO pop when a row is ready; the popped row is
                    // written to psum memory the following cycle
                    if (bus.ofifo_valid && (cnt < C_NACT)) begin
                        inst_q[6] <= 1'b1;
                        cnt       <= cnt + 16'd1;
                    end
                    if (inst_q[6]) begin
                        inst_q[32]    <= 1'b0;
                        inst_q[31]    <= 1'b0;
                        inst_q[30:20] <= addr;
                        addr          <= addr + 11'd1;
                        sub           <= sub + 16'd1;
                        if (sub == C_NACT - 16'd1) begin
                            cnt <= 16'd0;
                            sub <= 16'd0;
                            if (k == C_KSZ - 16'd1) begin
                                state <= ACC;
                                addr  <= psum_base;
                                jbase <= psum_base;
                            end else begin
                                state <= KLD_L0;
                                k     <= k + 16'd1;
                                xbase <= xbase + A_COL;
                                addr  <= xbase + A_COL;
                                abase <= abase + A_NACT;
                                pbase <= pbase + A_NACT;
                            end
                        end
                    end
                end

                ACC: begin
                    // partial k is the inner loop: stride n_act, then next output
                    inst_q[33]    <= 1'b1;
                    inst_q[32]    <= 1'b0;
                    inst_q[31]    <= 1'b1;
                    inst_q[30:20] <= addr;
                    if (sub == C_KSZ - 16'd1) begin
                        sub   <= 16'd0;
                        addr  <= jbase + 11'd1;
                        jbase <= jbase + 11'd1;
                        if (cnt == C_NACT - 16'd1) begin
                            state <= FIN;
                            cnt   <= 16'd0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end else begin
                        sub  <= sub + 16'd1;
                        addr <= addr + A_NACT;
                    end
                end

                FIN: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CORE_SEQ_PERF_EN
    // Saturating busy-cycle and DRAIN-stall counters, cleared per tile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
            cycle_cnt <= 16'd0;
        end else if ((state == IDLE) && bus.start) begin
            stall_cnt <= 16'd0;
            cycle_cnt <= 16'd0;
        end else begin
            if ((state != IDLE) && (cycle_cnt != 16'hFFFF)) begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end
            if ((state == DRAIN) && !bus.ofifo_valid && (cnt < C_NACT) &&
                (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_seq.sv
// Testbench for core_seq: a default-parameter instance and a small
// (ksize=1, n_act=4) instance share one clock and reset.  Instruction
// words are traced each cycle and checked against address/count lists
// computed from the tile rules.
module tb_core_seq;

    localparam logic [35:0] IDLE_W = 36'h1_8_0_0_C_0_0_0_0;
    localparam int COLP = 8;
    localparam int KB   = 0;
    localparam int AB   = 1024;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic ofifo_valid = 1'b1;
    logic sel = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    core_seq_if bus_a ();
    core_seq_if bus_b ();

    assign bus_a.start       = start & ~sel;
    assign bus_b.start       = start & sel;
    assign bus_a.ofifo_valid = ofifo_valid;
    assign bus_b.ofifo_valid = ofifo_valid;

`ifdef CORE_SEQ_PERF_EN
    logic [15:0] stall_a, cyc_a, stall_b, cyc_b;
`endif

    core_seq dut_a (
        .clk      (clk),
        .reset    (reset),
`ifdef CORE_SEQ_PERF_EN
        .stall_cnt(stall_a),
        .cycle_cnt(cyc_a),
`endif
        .bus      (bus_a)
    );

    core_seq #(.ksize(1), .n_act(4)) dut_b (
        .clk      (clk),
        .reset    (reset),
`ifdef CORE_SEQ_PERF_EN
        .stall_cnt(stall_b),
        .cycle_cnt(cyc_b),
`endif
        .bus      (bus_b)
    );

    initial forever #5 clk = ~clk;

    logic [35:0] mon_inst;
    logic        mon_busy, mon_done;
    assign mon_inst = sel ? bus_b.inst : bus_a.inst;
    assign mon_busy = sel ? bus_b.busy : bus_a.busy;
    assign mon_done = sel ? bus_b.done : bus_a.done;

    logic [35:0] tr[$];
    logic [35:0] ref_tr[$];
    bit rec = 1'b0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int n_wr_seen = 0;
    bit act_seen = 1'b0;
    bit gap_used = 1'b0;
    int gap_idx = 0;

    function automatic bit xrd(input logic [35:0] w);
        return !w[19] && w[18];
    endfunction
    function automatic bit pwr(input logic [35:0] w);
        return !w[32] && !w[31];
    endfunction
    function automatic bit prd(input logic [35:0] w);
        return !w[32] && w[31];
    endfunction

    // Trace one instruction word per cycle, just after the active edge.
    always @(posedge clk) begin
        #1;
        if (rec) begin
            tr.push_back(mon_inst);
            if (mon_done) done_cnt++;
            if (mon_busy) busy_cnt++;
            if (pwr(mon_inst)) n_wr_seen++;
            if (xrd(mon_inst) && (mon_inst[17:7] >= 11'(AB))) act_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ofifo_valid tied 1; 1: random; 2: one 10-cycle gap after 2 writes
    task automatic run_tile(input int mode, input int s1, input int s2);
        int post;
        int gap_left;
        post = 0;
        gap_left = 0;
        tr.delete();
        done_cnt = 0;
        busy_cnt = 0;
        n_wr_seen = 0;
        act_seen = 1'b0;
        gap_used = 1'b0;
        @(negedge clk);
        ofifo_valid = 1'b1;
        rec = 1'b1;
        start = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            start = (cyc == s1) || (cyc == s2);
            case (mode)
                1: ofifo_valid = ($urandom_range(0, 3) != 0);
                2: begin
                    if (gap_left > 0) begin
                        ofifo_valid = 1'b0;
                        gap_left--;
                    end else if (!gap_used && (n_wr_seen >= 2)) begin
                        gap_used = 1'b1;
                        gap_idx = tr.size();
                        ofifo_valid = 1'b0;
                        gap_left = 9;
                    end else begin
                        ofifo_valid = 1'b1;
                    end
                end
                default: ofifo_valid = 1'b1;
            endcase
            if (done_cnt > 0) begin
                post++;
                if (post > 3) break;
            end
        end
        start = 1'b0;
        ofifo_valid = 1'b1;
        rec = 1'b0;
    endtask

    // Check the traced tile against the tile rules for K positions, N outputs.
    task automatic analyze(input string tg, input int K, input int N);
        logic [10:0] xr[$];
        logic [10:0] pw[$];
        logic [10:0] pr[$];
        logic [10:0] ex[$];
        int n_load, n_exec, n_l0wr, n_l0rd, n_ord, n33;
        int bad_l0wr, bad_wr, bad_ex, bad_hi, diff;
        logic [35:0] w, p, p2;
        n_load = 0; n_exec = 0; n_l0wr = 0; n_l0rd = 0; n_ord = 0; n33 = 0;
        bad_l0wr = 0; bad_wr = 0; bad_ex = 0; bad_hi = 0;
        for (int t = 0; t < tr.size(); t++) begin
            w  = tr[t];
            p  = (t > 0) ? tr[t-1] : IDLE_W;
            p2 = (t > 1) ? tr[t-2] : IDLE_W;
            if (xrd(w)) xr.push_back(w[17:7]);
            if (pwr(w)) pw.push_back(w[30:20]);
            if (prd(w)) pr.push_back(w[30:20]);
            n_load += int'(w[0]);
            n_exec += int'(w[1]);
            n_l0wr += int'(w[2]);
            n_l0rd += int'(w[3]);
            n_ord  += int'(w[6]);
            n33    += int'(w[33]);
            if (w[2] != xrd(p)) bad_l0wr++;
            if (pwr(w) != p[6]) bad_wr++;
            if (w[1] != (xrd(p2) && (p2[17:7] >= 11'(AB)))) bad_ex++;
            if (w[35] || w[34]) bad_hi++;
        end
        for (int kk = 0; kk < K; kk++) begin
            for (int c = 0; c < COLP; c++) ex.push_back(11'(KB + kk * COLP + c));
            for (int j = 0; j < N; j++) ex.push_back(11'(AB + kk * N + j));
        end
        chk({tg, "_xread_cnt"}, xr.size(), ex.size());
        diff = 0;
        foreach (ex[i]) if (i >= xr.size() || xr[i] !== ex[i]) diff++;
        chk({tg, "_xread_addr_errs"}, diff, 0);
        ex.delete();
        for (int kk = 0; kk < K; kk++)
            for (int d = 0; d < N; d++) ex.push_back(11'(kk * N + d));
        chk({tg, "_pwrite_cnt"}, pw.size(), ex.size());
        diff = 0;
        foreach (ex[i]) if (i >= pw.size() || pw[i] !== ex[i]) diff++;
        chk({tg, "_pwrite_addr_errs"}, diff, 0);
        ex.delete();
        for (int j = 0; j < N; j++)
            for (int kk = 0; kk < K; kk++) ex.push_back(11'(kk * N + j));
        chk({tg, "_acc_read_cnt"}, pr.size(), ex.size());
        diff = 0;
        foreach (ex[i]) if (i >= pr.size() || pr[i] !== ex[i]) diff++;
        chk({tg, "_acc_read_addr_errs"}, diff, 0);
        chk({tg, "_acc_bit_cycles"}, n33, K * N);
        chk({tg, "_load_cycles"}, n_load, K * COLP);
        chk({tg, "_exec_cycles"}, n_exec, K * N);
        chk({tg, "_l0wr_cycles"}, n_l0wr, K * (COLP + N));
        chk({tg, "_l0rd_cycles"}, n_l0rd, K * (COLP + N));
        chk({tg, "_ofifo_rd_cycles"}, n_ord, K * N);
        chk({tg, "_l0wr_timing_errs"}, bad_l0wr, 0);
        chk({tg, "_pwrite_timing_errs"}, bad_wr, 0);
        chk({tg, "_exec_timing_errs"}, bad_ex, 0);
        chk({tg, "_mode_bits_set"}, bad_hi, 0);
        chk({tg, "_done_pulses"}, done_cnt, 1);
        chk({tg, "_inst_after_done"}, tr[tr.size()-1], IDLE_W);
    endtask

    initial begin
        int diff;
        int cnt;
        bit found;

        // reset, then idle
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_inst", bus_a.inst, IDLE_W);
            chk("idle_busy", bus_a.busy, 1'b0);
            chk("idle_done", bus_a.done, 1'b0);
        end

        // small tile: ksize=1, n_act=4
        sel = 1'b1;
        run_tile(0, -1, -1);
        analyze("small", 1, 4);
        sel = 1'b0;

        // default tile, reference trace
        run_tile(0, -1, -1);
        analyze("dflt", 9, 36);
        chk("dflt_acc_rd0", tr.size() > 0, 1'b1);
        begin
            logic [10:0] f[$];
            foreach (tr[i]) if (prd(tr[i])) f.push_back(tr[i][30:20]);
            chk("dflt_acc_first_cnt", f.size() >= 4, 1'b1);
            if (f.size() >= 4) begin
                chk("dflt_acc_first0", f[0], 11'd0);
                chk("dflt_acc_first1", f[1], 11'd36);
                chk("dflt_acc_first2", f[2], 11'd72);
                chk("dflt_acc_first3", f[3], 11'd108);
            end
        end
`ifdef CORE_SEQ_PERF_EN
        chk("dflt_cycle_cnt", cyc_a, busy_cnt);
        chk("dflt_stall_cnt", stall_a, 0);
`endif
        ref_tr = tr;

        // extra start pulses while busy must not disturb the sequence
        run_tile(0, 50, 600);
        chk("restart_trace_len", tr.size(), ref_tr.size());
        diff = 0;
        foreach (ref_tr[i]) if (i >= tr.size() || tr[i] !== ref_tr[i]) diff++;
        chk("restart_trace_diffs", diff, 0);

        // 10-cycle OFIFO gap mid-DRAIN
        run_tile(2, -1, -1);
        chk("gap_taken", gap_used, 1'b1);
        cnt = 0;
        for (int t = gap_idx; t < gap_idx + 10 && t < tr.size(); t++) cnt += int'(tr[t][6]);
        chk("gap_no_ofifo_rd", cnt, 0);
        cnt = 0;
        for (int t = gap_idx + 1; t < gap_idx + 11 && t < tr.size(); t++) cnt += int'(pwr(tr[t]));
        chk("gap_no_pwrite", cnt, 0);
        analyze("gap", 9, 36);
`ifdef CORE_SEQ_PERF_EN
        chk("gap_stall_cnt", stall_a, 10);
        chk("gap_cycle_cnt", cyc_a, busy_cnt);
`endif

        // random OFIFO availability
        run_tile(1, -1, -1);
        analyze("rand", 9, 36);

        // asynchronous reset during ALD_EXEC
        tr.delete();
        done_cnt = 0;
        act_seen = 1'b0;
        @(negedge clk);
        rec = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (act_seen) found = 1'b1;
        end
        chk("rst_reached_ald", found, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_inst_async", bus_a.inst, IDLE_W);
        chk("rst_busy_async", bus_a.busy, 1'b0);
        chk("rst_done_async", bus_a.done, 1'b0);
        rec = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_tile(0, -1, -1);
        analyze("post_rst", 9, 36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
